// File: rtl/sync_carrier_gen.sv
// sync_carrier_gen: multi-channel sawtooth/triangle carrier generator with phase offsets and sync pulses
// Ports: CLK/RST (async active-high); iEN count enable; iMODE 0=saw 1=tri; iPERIOD/iPHASE/iLOAD shadow load;
//        oCNT/oDIR/oSYNC per channel; oWRAP reference wrap pulse; oPENDING load waiting for a wrap.
// Optional: define EXT_SYNC_EN to add iEXT_SYNC, a synchronous restart of all counters.
module sync_carrier_gen #(
  parameter int WIDTH = 16,
  parameter int CHANNELS = 2,
  parameter int DEFAULT_PERIOD = 4000
)(
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      iEN,
  input  logic                      iMODE,
  input  logic [WIDTH-1:0]          iPERIOD,
  input  logic [CHANNELS*WIDTH-1:0] iPHASE,
  input  logic                      iLOAD,
`ifdef EXT_SYNC_EN
  input  logic                      iEXT_SYNC,
`endif
  output logic [CHANNELS*WIDTH-1:0] oCNT,
  output logic [CHANNELS-1:0]       oDIR,
  output logic [CHANNELS-1:0]       oSYNC,
  output logic                      oWRAP,
  output logic                      oPENDING
);
  typedef logic [WIDTH-1:0] w_t;
  typedef logic [WIDTH:0] dc_t;
  localparam w_t DEF_PE = w_t'(DEFAULT_PERIOD < 2 ? 2 : DEFAULT_PERIOD);
  // {dir,cnt} at a restart; triangle offsets past the peak land on the down-slope
  function automatic dc_t start_pos(w_t ph, w_t pe, logic tri_m);
    dc_t twice, lim, p;
    twice = {pe, 1'b0};
    lim = tri_m ? twice - dc_t'(1) : {1'b0, pe};
    p = {1'b0, ph} > lim ? lim : {1'b0, ph};
    return p > {1'b0, pe} ? {1'b0, w_t'(twice - p)} : {1'b1, p[WIDTH-1:0]};
  endfunction
  function automatic dc_t step(w_t c, logic d, w_t pe, logic tri_m);
    return !tri_m ? {1'b1, c == pe ? w_t'(0) : w_t'(c + 1'b1)}
         : d ? (c == pe ? {1'b0, w_t'(pe - 1'b1)} : {1'b1, w_t'(c + 1'b1)})
         : (c == w_t'(1) ? {1'b1, w_t'(0)} : {1'b0, w_t'(c - 1'b1)});
  endfunction
  function automatic logic is_sync(w_t c, w_t pe, logic tri_m);
    return tri_m ? c == w_t'(0) : c == pe;
  endfunction
  w_t per_q, pend_per, ref_cnt, a_pe, ld_per;
  w_t ph_q[CHANNELS], cnt_q[CHANNELS], a_ph[CHANNELS];
  dc_t ch_n[CHANNELS], ref_n;
  logic mode_q, pend_mode, pend_q, ref_dir, wrap_q, ext, apply, take, a_mode;
  logic [CHANNELS-1:0] dir_q, sync_q;
  logic [CHANNELS*WIDTH-1:0] pend_ph, ld_ph;
`ifdef EXT_SYNC_EN
  assign ext = iEXT_SYNC;
`else
  assign ext = 1'b0;
`endif
  // a load arriving in the wrap cycle bypasses the shadow registers
  always_comb begin
    apply = ext | (wrap_q & (pend_q | iLOAD));
    take = apply & (pend_q | iLOAD);
    ld_per = iLOAD ? iPERIOD : pend_per;
    ld_ph = iLOAD ? iPHASE : pend_ph;
    a_mode = take ? (iLOAD ? iMODE : pend_mode) : mode_q;
    a_pe = take ? (ld_per < w_t'(2) ? w_t'(2) : ld_per) : per_q;
    ref_n = apply ? {1'b1, w_t'(0)} : iEN ? step(ref_cnt, ref_dir, per_q, mode_q) : {ref_dir, ref_cnt};
    for (int i = 0; i < CHANNELS; i++) begin
      a_ph[i] = take ? ld_ph[i*WIDTH +: WIDTH] : ph_q[i];
      ch_n[i] = apply ? start_pos(a_ph[i], a_pe, a_mode)
              : iEN ? step(cnt_q[i], dir_q[i], per_q, mode_q) : {dir_q[i], cnt_q[i]};
    end
  end
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      per_q <= DEF_PE;
      mode_q <= 1'b0;
      pend_q <= 1'b0;
      pend_per <= '0;
      pend_mode <= 1'b0;
      pend_ph <= '0;
      ref_cnt <= '0;
      ref_dir <= 1'b1;
      wrap_q <= 1'b0;
      dir_q <= '1;
      sync_q <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        ph_q[i] <= w_t'(i * DEFAULT_PERIOD / CHANNELS);
        cnt_q[i] <= w_t'(i * DEFAULT_PERIOD / CHANNELS);
      end
    end else begin
      per_q <= a_pe;
      mode_q <= a_mode;
      pend_q <= !apply & (pend_q | iLOAD);
      if (iLOAD) begin
        pend_per <= iPERIOD;
        pend_mode <= iMODE;
        pend_ph <= iPHASE;
      end
      {ref_dir, ref_cnt} <= ref_n;
      wrap_q <= !ext & iEN & is_sync(ref_n[WIDTH-1:0], a_pe, a_mode);
      for (int i = 0; i < CHANNELS; i++) begin
        ph_q[i] <= a_ph[i];
        cnt_q[i] <= ch_n[i][WIDTH-1:0];
        dir_q[i] <= ch_n[i][WIDTH];
        sync_q[i] <= !ext & iEN & is_sync(ch_n[i][WIDTH-1:0], a_pe, a_mode);
      end
    end
  end
  for (genvar g = 0; g < CHANNELS; g++) begin : g_out
    assign oCNT[g*WIDTH +: WIDTH] = cnt_q[g];
  end
  assign oDIR = dir_q;
  assign oSYNC = sync_q;
  assign oWRAP = wrap_q;
  assign oPENDING = pend_q;
endmodule
